// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, plus WIDTH-cycle shift-add
// multiply and restoring divide. Results and flags are registered and held until the next done.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_r,
  output logic [WIDTH-1:0] data_h,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_TRA = 4'd2;
  localparam logic [3:0] OP_TRB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;

  logic [1:0]       state;
  logic             is_mul;
  logic [CW-1:0]    cnt;
  // hi: partial product high word / partial remainder; lo: multiplier / quotient shift register.
  logic [WIDTH-1:0] hi, lo, mcand;

  logic [WIDTH-1:0] res_r, res_h;
  logic             res_c, res_v;
  logic             long_op;

  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   sum, shifted;

  assign long_op = (op == OP_MUL) || ((op == OP_DIV) && (data_b != '0));

  // Single-cycle results, computed straight from the operands being accepted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    res_r = '0;
    res_h = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_ADD: begin
        {res_c, res_r} = {1'b0, data_a} + {1'b0, data_b};
        res_v = (data_a[WIDTH-1] == data_b[WIDTH-1]) && (res_r[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_SUB: begin
        {res_c, res_r} = {1'b0, data_a} - {1'b0, data_b};
        res_v = (data_a[WIDTH-1] != data_b[WIDTH-1]) && (res_r[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_TRA: res_r = data_a;
      OP_TRB: res_r = data_b;
      OP_AND: res_r = data_a & data_b;
      OP_OR:  res_r = data_a | data_b;
      OP_XOR: res_r = data_a ^ data_b;
      OP_SHL: begin
        res_r = {data_a[WIDTH-2:0], 1'b0};
        res_c = data_a[WIDTH-1];
      end
      OP_SHR: begin
        res_r = {1'b0, data_a[WIDTH-1:1]};
        res_c = data_a[0];
      end
      OP_DIV: begin
        // Only reached with a zero divisor; nonzero divisors take the iterative path.
        res_r = '1;
        res_h = data_a;
        res_v = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    step_hi = hi;
    step_lo = lo;
    sum     = '0;
    shifted = '0;
    if (is_mul) begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo[WIDTH-1:1]};
    end else begin
      shifted = {hi, lo[WIDTH-1]};
      if (shifted >= {1'b0, mcand}) begin
        step_hi = shifted[WIDTH-1:0] - mcand;
        step_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shifted[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register, including datapath ones, is reset so an aborted operation leaves nothing behind.
    if (!reset_n) begin
      state  <= S_IDLE;
      is_mul <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      data_r <= '0;
      data_h <= '0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      cf     <= 1'b0;
      vf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (long_op) begin
              state  <= S_RUN;
              busy   <= 1'b1;
              is_mul <= (op == OP_MUL);
              hi     <= '0;
              lo     <= data_a;
              mcand  <= data_b;
              cnt    <= CW'(WIDTH - 1);
            end else begin
              state  <= S_FIN;
              done   <= 1'b1;
              data_r <= res_r;
              data_h <= res_h;
              zf     <= (res_r == '0);
              nf     <= res_r[WIDTH-1];
              cf     <= res_c;
              vf     <= res_v;
            end
          end
        end
        S_RUN: begin
          hi <= step_hi;
          lo <= step_lo;
          if (cnt == '0) begin
            state  <= S_FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            data_r <= step_lo;
            data_h <= step_hi;
            zf     <= (step_lo == '0);
            nf     <= step_lo[WIDTH-1];
            cf     <= is_mul && (step_hi != '0);
            vf     <= is_mul && (step_hi != '0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result data width (legal range 4..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  4  operation code: 0 ADD, 1 SUB, 2 TRA, 3 TRB, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR, 9 MUL, 10 DIV; 11-15 illegal.
REQ-006 SHALL have ports data_a, data_b  input  WIDTH  operands, unsigned unless stated.
REQ-007 SHALL have port busy  output  1  high while a multi-cycle operation runs.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results and flags are valid.
REQ-009 SHALL have port data_r  output  WIDTH  result, low word or quotient.
REQ-010 SHALL have port data_h  output  WIDTH  high product word or remainder; 0 for other ops.
REQ-011 SHALL have ports zf, nf, cf, vf  output  1 each  zero, negative, carry/borrow, overflow flags.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIN.
REQ-013 SHALL, in IDLE with start=1, capture op, data_a and data_b; start SHALL be ignored in RUN and FIN.
REQ-014 SHALL, for ops 0-8 and illegal ops, register the results at the accepting edge, go to FIN, and pulse done in the following cycle (latency 1); busy SHALL stay 0.
REQ-015 SHALL, for MUL and DIV with nonzero divisor, go to RUN and iterate one bit per cycle for exactly WIDTH cycles with busy=1, then go to FIN; done SHALL pulse WIDTH+1 cycles after the accepting edge.
REQ-016 SHALL leave FIN after one cycle and return to IDLE; a start in that IDLE cycle SHALL be accepted (back-to-back throughput).
REQ-017 SHALL hold data_r, data_h and the flags stable from done until the next done; intermediate iteration values SHALL NOT appear on the outputs.
REQ-018 ADD: data_r = (a+b) mod 2^WIDTH, cf = carry out, vf = signed two's-complement overflow.
REQ-019 SUB: data_r = (a-b) mod 2^WIDTH, cf = 1 iff a<b unsigned (borrow), vf = signed overflow.
REQ-020 TRA/TRB/AND/OR/XOR: data_r = a, b, a&b, a|b, a^b respectively; cf = vf = 0.
REQ-021 SHL/SHR: shift data_a by one, zero fill; cf = bit shifted out; vf = 0.
REQ-022 MUL: {data_h,data_r} = a*b (2*WIDTH bits, shift-add); cf = vf = (data_h != 0).
REQ-023 DIV: data_r = a/b, data_h = a mod b (restoring division); cf = vf = 0.
REQ-024 DIV with b=0: no RUN phase, latency 1, data_r = all ones, data_h = a, vf = 1, cf = 0.
REQ-025 Illegal op: data_r = data_h = 0, cf = vf = 0, done pulses with latency 1.
REQ-026 For all ops: zf = (data_r == 0), nf = data_r[WIDTH-1].

Reset
REQ-027 SHALL, on reset_n=0, asynchronously force state IDLE, busy=0, done=0, data_r=0, data_h=0, zf=nf=cf=vf=0, and clear all internal registers.
REQ-028 SHALL abort any MUL/DIV in progress when reset is asserted mid-operation; no done SHALL be produced for it after reset release.
REQ-029 SHALL accept a start in the first rising edge after reset_n deasserts.

Verification (WIDTH=8)
REQ-030 ADD a=0x7F, b=0x01 -> 1 cycle later done=1, data_r=0x80, nf=1, vf=1, cf=0, zf=0; then ADD 0xFF+0x01 -> data_r=0x00, zf=1, cf=1, vf=0.
REQ-031 SUB a=0x03, b=0x05 -> data_r=0xFE, cf=1, nf=1, vf=0.
REQ-032 MUL a=0xFF, b=0xFF -> busy high for 8 cycles, done exactly 9 cycles after start, data_h=0xFE, data_r=0x01, cf=vf=1; start pulses during busy are ignored.
REQ-033 DIV a=100, b=7 -> done after 9 cycles, data_r=14, data_h=2; then DIV a=0x2A, b=0 -> done after 1 cycle, data_r=0xFF, data_h=0x2A, vf=1.
REQ-034 Assert reset_n=0 during cycle 4 of a MUL -> all outputs 0 immediately; release; no done appears; a new ADD 2+3 then yields 5 after 1 cycle.
REQ-035 Illegal op 12 -> done after 1 cycle, data_r=0, zf=1; SHR a=0x01 back-to-back in the next IDLE cycle -> data_r=0x00, cf=1, zf=1.
